// File: rtl/cpu_pkg.sv
// Shared constants and types for the RV32I fetch stage.
package cpu_pkg;

    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam logic [6:0]  OPCODE_JALR = 7'b1100111;
    localparam logic [31:0] PC_STEP     = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Instruction addresses are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_perf_counter.sv
// Delivered-instruction and bubble counters for the fetch stage; both wrap at 2^32.
module if_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_evt,
    input  logic        bubble_evt,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (fetch_evt)  fetch_cnt  <= fetch_cnt + 32'd1;
            if (bubble_evt) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, keeps one imem request in flight, presents one instruction or a bubble.
// Optional performance counters are built when IF_FETCH_PERF_EN is defined.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] now_pc_o,
    output logic [31:0] inst_o,
    output logic        nop_o,
    output logic        is_jalr_o
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] bubble_cnt_o
`endif
);

    localparam logic [31:0] START_PC = word_align(RESET_PC);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  pending_pc, pending_nxt;
    logic [31:0]  buf_inst, buf_pc;
    logic         buf_load;
    logic         started;
    logic         req;
    logic         nop;
    logic [31:0]  pres_inst, pres_pc;
    logic [31:0]  redir_pc;
    logic [31:0]  pc_inc;

    assign redir_pc = word_align(redirect_pc_i);
    assign pc_inc   = pc + PC_STEP;

    // started holds the request line low from reset until the first clock edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= START_PC;
            pending_pc <= START_PC;
            buf_inst   <= NOP_INST;
            buf_pc     <= START_PC;
            started    <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pending_pc <= pending_nxt;
            started    <= 1'b1;
            if (buf_load) begin
                buf_inst <= imem_rdata_i;
                buf_pc   <= pc;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        pending_nxt = pending_pc;
        buf_load    = 1'b0;
        req         = 1'b0;
        nop         = 1'b1;
        pres_inst   = NOP_INST;
        pres_pc     = pc;

        unique case (state)
            FETCH: begin
                if (!started) begin
                    // No request is in flight yet, so a redirect simply retargets the PC.
                    if (redirect_i) pc_nxt = redir_pc;
                end else begin
                    req = 1'b1;
                    if (imem_ack_i) begin
                        if (redirect_i) begin
                            pc_nxt = redir_pc;
                        end else begin
                            pc_nxt    = pc_inc;
                            pres_inst = imem_rdata_i;
                            nop       = 1'b0;
                            if (stall_i) begin
                                buf_load  = 1'b1;
                                state_nxt = HOLD;
                            end
                        end
                    end else if (redirect_i) begin
                        // The in-flight request cannot be withdrawn; wait it out.
                        pending_nxt = redir_pc;
                        state_nxt   = DRAIN;
                    end
                end
            end

            HOLD: begin
                if (redirect_i) begin
                    pc_nxt    = redir_pc;
                    state_nxt = FETCH;
                end else begin
                    pres_inst = buf_inst;
                    pres_pc   = buf_pc;
                    nop       = 1'b0;
                    if (!stall_i) state_nxt = FETCH;
                end
            end

            DRAIN: begin
                req = 1'b1;
                if (imem_ack_i) begin
                    pc_nxt    = redirect_i ? redir_pc : pending_pc;
                    state_nxt = FETCH;
                end else if (redirect_i) begin
                    pending_nxt = redir_pc;
                end
            end

            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    assign imem_req_o  = req;
    assign imem_addr_o = pc;
    assign nop_o       = nop;
    assign inst_o      = pres_inst;
    assign now_pc_o    = pres_pc;
    assign is_jalr_o   = !nop && (pres_inst[6:0] == OPCODE_JALR);

`ifdef IF_FETCH_PERF_EN
    if_perf_counter u_perf (
        .clk        (clk),
        .rst        (rst),
        .fetch_evt  (!nop && !stall_i && !redirect_i),
        .bubble_evt (nop && !stall_i),
        .fetch_cnt  (fetch_cnt_o),
        .bubble_cnt (bubble_cnt_o)
    );
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus random stall/redirect/wait-state traffic,
// checked against an instruction-stream and memory-transaction reference model.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] now_pc_o;
    logic [31:0] inst_o;
    logic        nop_o;
    logic        is_jalr_o;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] bubble_cnt_o;
`endif

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .now_pc_o      (now_pc_o),
        .inst_o        (inst_o),
        .nop_o         (nop_o),
        .is_jalr_o     (is_jalr_o)
`ifdef IF_FETCH_PERF_EN
        ,
        .fetch_cnt_o   (fetch_cnt_o),
        .bubble_cnt_o  (bubble_cnt_o)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory image: address-dependent word, one fixed jalr at 0x40, others jalr when a[4:2]==6.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [6:0] op;
        if (a == 32'h0000_0040) return 32'h0000_80E7;
        op = (a[4:2] == 3'd6) ? 7'h67 : 7'h13;
        return {a[26:2] ^ 25'h1234567, op};
    endfunction

    // Reference model state
    logic [31:0] exp_pc;          // next PC the architectural stream must deliver
    logic        mreq_active;
    int          mwait;
    logic [31:0] maddr;
    logic        drain_pend;
    logic [31:0] drain_tgt;
    logic        exp_next_valid;
    logic [31:0] exp_next_addr;
    logic        holding;
    logic [31:0] hold_addr;
    int          wait_cfg;        // -1: random wait states
    int          idle;
    logic [31:0] fetch_exp, bubble_exp;

    // Observations of the last step, for directed checks
    logic        o_req, o_nop, o_jalr;
    logic [31:0] o_addr, o_pc, o_inst;

    task automatic step(input logic st, input logic rd, input logic [31:0] tgt);
        logic        ack;
        logic        deliver;
        logic [31:0] atgt;
        @(negedge clk);
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = tgt;
        atgt          = tgt & 32'hFFFF_FFFC;

        if (exp_next_valid) begin
            chk("next_req", {31'd0, imem_req_o}, 32'd1);
            chk("next_addr", imem_addr_o, exp_next_addr);
            exp_next_valid = 1'b0;
        end
        if (holding) chk("hold_noreq", {31'd0, imem_req_o}, 32'd0);

        ack = 1'b0;
        if (imem_req_o) begin
            chk("addr_align", {30'd0, imem_addr_o[1:0]}, 32'd0);
            if (!mreq_active) begin
                mreq_active = 1'b1;
                maddr       = imem_addr_o;
                mwait       = (wait_cfg < 0) ? (($urandom_range(0, 7) < 4) ? 0 : int'($urandom_range(1, 3)))
                                             : wait_cfg;
            end else begin
                chk("addr_stable", imem_addr_o, maddr);
            end
            ack = (mwait == 0);
        end else if (mreq_active) begin
            chk("req_withdrawn", {31'd0, imem_req_o}, 32'd1);
            mreq_active = 1'b0;
        end
        imem_ack_i   = ack;
        imem_rdata_i = ack ? mem_word(maddr) : $urandom;
        #1;

        o_req = imem_req_o; o_addr = imem_addr_o; o_nop = nop_o;
        o_pc = now_pc_o; o_inst = inst_o; o_jalr = is_jalr_o;

`ifdef IF_FETCH_PERF_EN
        chk("fetch_cnt", fetch_cnt_o, fetch_exp);
        chk("bubble_cnt", bubble_cnt_o, bubble_exp);
`endif
        if (drain_pend) chk("drain_nop", {31'd0, nop_o}, 32'd1);
        if (holding && !rd) chk("hold_valid", {31'd0, nop_o}, 32'd0);
        if (nop_o) begin
            chk("nop_inst", inst_o, 32'h0000_0013);
            chk("nop_jalr", {31'd0, is_jalr_o}, 32'd0);
        end

        deliver = !nop_o && !st && !rd;
        if (deliver) begin
            chk("pc", now_pc_o, exp_pc);
            chk("inst", inst_o, mem_word(exp_pc));
            chk("jalr", {31'd0, is_jalr_o}, {31'd0, mem_word(exp_pc)[6:0] == 7'h67});
            exp_pc = exp_pc + 32'd4;
            fetch_exp++;
            idle = 0;
        end else begin
            idle++;
            if (idle > 80) begin
                chk("progress", idle, 0);
                idle = 0;
            end
        end
        if (nop_o && !st) bubble_exp++;

        // Transaction-level expectations for the following cycle
        if (holding && (!st || rd)) begin
            if (!rd) begin
                exp_next_valid = 1'b1;
                exp_next_addr  = hold_addr;
            end
            holding = 1'b0;
        end
        if (rd) begin
            exp_pc = atgt;
            if (imem_req_o && !ack) begin
                drain_pend = 1'b1;
                drain_tgt  = atgt;
            end else begin
                drain_pend     = 1'b0;
                exp_next_valid = 1'b1;
                exp_next_addr  = atgt;
            end
        end else if (drain_pend && ack) begin
            drain_pend     = 1'b0;
            exp_next_valid = 1'b1;
            exp_next_addr  = drain_tgt;
        end else if (ack && !st) begin
            exp_next_valid = 1'b1;
            exp_next_addr  = maddr + 32'd4;
        end else if (ack && st) begin
            holding   = 1'b1;
            hold_addr = maddr + 32'd4;
        end

        if (ack) mreq_active = 1'b0;
        else if (mreq_active) mwait--;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        stall_i = 1'b0; redirect_i = 1'b0; imem_ack_i = 1'b0;
        #1;
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_nop", {31'd0, nop_o}, 32'd1);
        chk("rst_inst", inst_o, 32'h0000_0013);
        chk("rst_pc", now_pc_o, RST_PC);
        chk("rst_jalr", {31'd0, is_jalr_o}, 32'd0);
`ifdef IF_FETCH_PERF_EN
        chk("rst_fcnt", fetch_cnt_o, 32'd0);
        chk("rst_bcnt", bubble_cnt_o, 32'd0);
`endif
        exp_pc = RST_PC; mreq_active = 1'b0; mwait = 0; maddr = '0;
        drain_pend = 1'b0; drain_tgt = '0; holding = 1'b0; hold_addr = '0;
        fetch_exp = '0; bubble_exp = '0; idle = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_req", {31'd0, imem_req_o}, 32'd0);
        chk("rel_nop", {31'd0, nop_o}, 32'd1);
        bubble_exp++;
        exp_next_valid = 1'b1;
        exp_next_addr  = RST_PC;
    endtask

    initial begin
        exp_next_valid = 1'b0; exp_next_addr = '0; wait_cfg = 0;
        do_reset();

        // Zero-wait streaming
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'd0);
            chk("zw_nop", {31'd0, o_nop}, 32'd0);
            chk("zw_pc", o_pc, RST_PC + 32'(4 * i));
        end

        // Two wait states: two bubbles before each instruction
        wait_cfg = 2;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 32'd0);
            chk("ws_nop", {31'd0, o_nop}, {31'd0, (i % 3) != 2});
        end

        // Stall at the ack of 0x200 for three cycles
        wait_cfg = 0;
        step(1'b0, 1'b1, 32'h200);
        step(1'b1, 1'b0, 32'd0);
        chk("st_addr", o_addr, 32'h200);
        step(1'b1, 1'b0, 32'd0);
        chk("st_hold_req", {31'd0, o_req}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        chk("st_hold_pc", o_pc, 32'h200);
        step(1'b0, 1'b0, 32'd0);
        chk("st_rel_pc", o_pc, 32'h200);
        step(1'b0, 1'b0, 32'd0);
        chk("st_next", o_addr, 32'h204);

        // Redirect while a request waits, then a double redirect in DRAIN
        step(1'b0, 1'b1, 32'h300);
        wait_cfg = 3;
        step(1'b0, 1'b0, 32'd0);
        chk("dr_addr", o_addr, 32'h300);
        step(1'b0, 1'b1, 32'h400);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        chk("dr_tgt1", o_addr, 32'h400);
        step(1'b0, 1'b1, 32'h600);
        step(1'b0, 1'b1, 32'h500);
        step(1'b0, 1'b0, 32'd0);
        wait_cfg = 0;
        step(1'b0, 1'b0, 32'd0);
        chk("dr_tgt2", o_addr, 32'h500);

        // PC wrap, low redirect bits ignored
        step(1'b0, 1'b1, 32'hFFFF_FFFE);
        step(1'b0, 1'b0, 32'd0);
        chk("wrap_pc0", o_pc, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'd0);
        chk("wrap_pc1", o_pc, 32'h0);

        // jalr detection
        step(1'b0, 1'b1, 32'h40);
        step(1'b0, 1'b0, 32'd0);
        chk("jalr_inst", o_inst, 32'h0000_80E7);
        chk("jalr_flag", {31'd0, o_jalr}, 32'd1);
        step(1'b0, 1'b0, 32'd0);
        chk("jalr_next", {31'd0, o_jalr}, 32'd0);

        // Reset while a request is waiting
        wait_cfg = 3;
        step(1'b0, 1'b0, 32'd0);
        do_reset();
        wait_cfg = 0;
        step(1'b0, 1'b0, 32'd0);
        chk("rst_restart", o_addr, RST_PC);

        // Random traffic
        wait_cfg = -1;
        for (int i = 0; i < 3000; i++) begin
            logic        st, rd;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 32'h3FFF));
            if ($urandom_range(0, 499) == 0) do_reset();
            else step(st, rd, tgt);
        end
        step(1'b0, 1'b0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the 5-stage RV32I pipeline. It owns the PC, issues single-outstanding requests to instruction memory, and presents one instruction per cycle (or a bubble) to the IF/ID pipeline register. It absorbs memory wait states, downstream stalls and control-flow redirects from EX.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- stall_i  in  1  hazard unit holds IF/ID this cycle.
- redirect_i  in  1  taken branch / jal / jalr resolved; flush and refetch.
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored, treated as 00.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch address; always word aligned.
- imem_ack_i  in  1  memory returns data this cycle; may be same cycle as request.
- imem_rdata_i  in  32  instruction word, valid when imem_ack_i.
- now_pc_o  out  32  PC of presented instruction.
- inst_o  out  32  presented instruction; 32'h0000_0013 when nop_o.
- nop_o  out  1  no valid instruction this cycle; IF/ID inserts bubble.
- is_jalr_o  out  1  inst_o[6:0]==7'b1100111 and !nop_o.
- fetch_cnt_o  out  32  instructions delivered (IF_FETCH_PERF_EN only).
- bubble_cnt_o  out  32  cycles with nop_o && !stall_i (IF_FETCH_PERF_EN only).

## Operation
- Registers: pc, pending_pc, buf_inst, buf_pc, state ∈ {FETCH, HOLD, DRAIN}.
- Memory protocol: imem_req_o and imem_addr_o stay stable from assertion until the cycle imem_ack_i is high. At most one request is outstanding; a request is never withdrawn.
- FETCH: imem_req_o=1, imem_addr_o=pc.
  - ack && redirect_i: discard data; pc<=redirect_pc; stay FETCH; nop_o=1.
  - ack && stall_i: buf<=rdata/pc; pc<=pc+4; go HOLD; presented outputs are don't-care (IF/ID is holding).
  - ack otherwise: present rdata/pc combinationally (nop_o=0); pc<=pc+4.
  - no ack && redirect_i: pending_pc<=redirect_pc; go DRAIN; nop_o=1.
  - no ack: nop_o=1.
- HOLD: imem_req_o=0; present buf_inst/buf_pc, nop_o=0.
  - redirect_i: drop buffer; pc<=redirect_pc; go FETCH; nop_o=1.
  - !stall_i: instruction consumed; go FETCH.
- DRAIN: imem_req_o=1 with the old address; nop_o=1.
  - Another redirect_i overwrites pending_pc (the last one wins).
  - On ack: discard data; pc<=pending_pc, or redirect_pc_i if redirect is also active; go FETCH.
- Priority: rst > redirect_i > stall_i.
- pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0).

## Timing
- Reset (async, immediate): state=FETCH, pc=RESET_PC, imem_req_o=0, nop_o=1, inst_o=32'h13, now_pc_o=RESET_PC, is_jalr_o=0, counters=0.
- First request: the first clk edge after rst falls raises imem_req_o.
- Reset mid-request: the outstanding request is abandoned. The memory model must drop it; no response after reset is consumed.
- Zero-wait memory: one instruction per cycle, fetch-to-IF/ID latency 0 (combinational), registered by IF/ID.
- N wait states: N bubbles per instruction.
- Redirect penalty: target request issues the cycle after redirect_i, or the cycle after the drain ack when in DRAIN.

## Configuration
- IF_FETCH_PERF_EN defined: fetch_cnt_o increments on every cycle with !nop_o && !stall_i && !redirect_i; bubble_cnt_o increments on nop_o && !stall_i. Both are 32-bit, wrap, and reset to 0.
- IF_FETCH_PERF_EN undefined: both ports and counters are absent; there is no other behavioural change.

## Structure
- cpu_pkg: NOP_INST=32'h0000_0013, OPCODE_JALR=7'b1100111, fetch_state_t enum {FETCH, HOLD, DRAIN}.
- Sub-module if_perf_counter (two counters, instantiated only under IF_FETCH_PERF_EN).

## Test plan
- Zero-wait memory, no stall, RESET_PC=0x100: PCs 0x100, 0x104, 0x108 are presented on consecutive cycles with nop_o=0.
- Memory with 2 wait states: each instruction is preceded by 2 nop_o cycles; imem_addr_o is stable while waiting.
- stall_i high for 3 cycles at an ack of 0x200: buffered 0x200 is held in HOLD with no new request, then presented once; the next fetch is 0x204.
- redirect_i to 0x400 while a 0x300 request waits: DRAIN until ack, data discarded, next request is 0x400. A second redirect to 0x500 during DRAIN gives next request 0x500.
- RESET_PC=0xFFFF_FFFC: the second request is 0x0. rst pulsed mid-wait gives imem_req_o=0 immediately and a restart at RESET_PC.
- Returned word 0x000080E7 (jalr): is_jalr_o=1. Under IF_FETCH_PERF_EN, fetch_cnt_o/bubble_cnt_o match the scripted counts.
